// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory request and F/D register of the
// five-stage MIPS pipeline. Branch/jump targets are resolved from the F/D
// contents; redirects that resolve while a fetch is waiting are parked until
// the delay-slot fetch completes.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic [1:0]  PCSrc,
    input  logic        NPCOp,
    input  logic [31:0] RD1D,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PC8D
);

    logic [31:0] pc;
    logic        pending;
    logic [31:0] pending_target;
    logic [31:0] pcd_plus4;
    logic [31:0] br_off;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        redirect;

    assign pcd_plus4 = PCD + 32'd4;
    assign br_off    = {{14{InstrD[15]}}, InstrD[15:0], 2'b00};
    assign redirect  = (PCSrc == 2'b01) || (PCSrc == 2'b10);

    assign imem_addr = pc;
    assign imem_req  = reset & ~stall;
    assign PC8D      = PCD + 32'd8;

    // Redirect target from the instruction currently held in F/D.
    always_comb begin
        target = pcd_plus4 + 32'd4;
        unique case (PCSrc)
            2'b10:   target = {RD1D[31:2], 2'b00};
            2'b01:   target = NPCOp ? {pcd_plus4[31:28], InstrD[25:0], 2'b00}
                                    : pcd_plus4 + br_off;
            default: target = pc + 32'd4;
        endcase
    end

    // Next PC on a completed fetch: a live redirect beats a parked one.
    always_comb begin
        next_pc = pc + 32'd4;
        if (redirect)     next_pc = target;
        else if (pending) next_pc = pending_target;
    end

    // PC, F/D register and parked-redirect state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc             <= RESET_PC;
            InstrD         <= '0;
            PCD            <= '0;
            pending        <= 1'b0;
            pending_target <= '0;
        end else if (stall) begin
            // Hold everything; decode re-presents the redirect next cycle.
        end else if (imem_ready) begin
            InstrD  <= imem_rdata;
            PCD     <= pc;
            pc      <= {next_pc[31:2], 2'b00};
            pending <= 1'b0;
        end else begin
            // Waiting fetch: inject a nop bubble and park any redirect so the
            // delay-slot fetch still completes first.
            InstrD <= '0;
            PCD    <= '0;
            if (redirect) begin
                pending        <= 1'b1;
                pending_target <= {target[31:2], 2'b00};
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed fetch-stage scenarios with a scoreboard of
// expected F/D contents pushed at drive time and popped after each edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [1:0]  PCSrc;
    logic        NPCOp;
    logic [31:0] RD1D;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PC8D;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcd;
    } fd_t;

    fd_t sb[$];
    fd_t exp_fd;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    // Program image: beq +3 at 0x3000, j 0x0000C10 at 0x3008, filler elsewhere.
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        case (a)
            32'h0000_3000: return 32'h1000_0003;
            32'h0000_3008: return 32'h0800_0C10;
            default:       return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign imem_rdata = instr_at(imem_addr);

    fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .PCSrc(PCSrc), .NPCOp(NPCOp), .RD1D(RD1D),
        .InstrD(InstrD), .PCD(PCD), .PC8D(PC8D)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Assert reset mid-cycle, check the immediate reset state, release on a negedge.
    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        PCSrc = 2'b00; NPCOp = 1'b0; RD1D = '0;
        #1;
        chk("rst_addr",   imem_addr, 32'h0000_3000);
        chk("rst_req",    {31'd0, imem_req}, 32'd0);
        chk("rst_instrd", InstrD, 32'd0);
        chk("rst_pcd",    PCD, 32'd0);
        chk("rst_pc8d",   PC8D, 32'd8);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_fd.instr = '0;
        exp_fd.pcd   = '0;
        sb.delete();
    endtask

    // One pipeline cycle, entered and left on a negedge.
    task automatic cyc(input logic st, input logic rdy, input logic [1:0] src,
                       input logic np, input logic [31:0] rd1, input logic [31:0] exp_addr);
        fd_t got;
        stall = st; imem_ready = rdy; PCSrc = src; NPCOp = np; RD1D = rd1;
        #1;
        chk("imem_addr", imem_addr, exp_addr);
        chk("imem_req", {31'd0, imem_req}, {31'd0, ~st});
        if (!st) begin
            if (rdy) begin
                exp_fd.instr = instr_at(exp_addr);
                exp_fd.pcd   = exp_addr;
            end else begin
                exp_fd.instr = '0;
                exp_fd.pcd   = '0;
            end
        end
        sb.push_back(exp_fd);
        @(posedge clk);
        @(negedge clk);
        got = sb.pop_front();
        chk("instrd", InstrD, got.instr);
        chk("pcd",    PCD,    got.pcd);
        chk("pc8d",   PC8D,   got.pcd + 32'd8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish by 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        PCSrc = 2'b00; NPCOp = 1'b0; RD1D = '0;
        @(negedge clk);

        // Sequential fetch, then j at 0x3008 redirecting to 0x3040 after its slot.
        do_reset();
        cyc(0, 1, 2'b00, 0, 0, 32'h3000);
        cyc(0, 1, 2'b00, 0, 0, 32'h3004);
        cyc(0, 1, 2'b00, 0, 0, 32'h3008);
        cyc(0, 1, 2'b01, 1, 0, 32'h300C);
        cyc(0, 1, 2'b00, 0, 0, 32'h3040);

        // Taken beq +3 at 0x3000 -> 0x3010, then jr 0x3103 -> 0x3100.
        do_reset();
        cyc(0, 1, 2'b00, 0, 0, 32'h3000);
        cyc(0, 1, 2'b01, 0, 0, 32'h3004);
        cyc(0, 1, 2'b00, 0, 0, 32'h3010);
        cyc(0, 1, 2'b10, 0, 32'h0000_3103, 32'h3014);
        cyc(0, 1, 2'b00, 0, 0, 32'h3100);
        cyc(0, 1, 2'b00, 0, 0, 32'h3104);

        // beq resolving during a 2-cycle memory wait: parked, then applied once.
        do_reset();
        cyc(0, 1, 2'b00, 0, 0, 32'h3000);
        cyc(0, 0, 2'b01, 0, 0, 32'h3004);
        cyc(0, 0, 2'b00, 0, 0, 32'h3004);
        cyc(0, 1, 2'b00, 0, 0, 32'h3004);
        cyc(0, 1, 2'b00, 0, 0, 32'h3010);
        cyc(0, 1, 2'b00, 0, 0, 32'h3014);

        // 3-cycle stall with a branch in D; stall beats a not-ready memory.
        do_reset();
        cyc(0, 1, 2'b00, 0, 0, 32'h3000);
        cyc(1, 1, 2'b01, 0, 0, 32'h3004);
        cyc(1, 0, 2'b01, 0, 0, 32'h3004);
        cyc(1, 1, 2'b01, 0, 0, 32'h3004);
        cyc(0, 1, 2'b01, 0, 0, 32'h3004);
        cyc(0, 1, 2'b00, 0, 0, 32'h3010);

        // Reset while a redirect is parked: pending is discarded.
        do_reset();
        cyc(0, 1, 2'b00, 0, 0, 32'h3000);
        cyc(0, 0, 2'b01, 0, 0, 32'h3004);
        do_reset();
        cyc(0, 1, 2'b00, 0, 0, 32'h3000);
        cyc(0, 1, 2'b00, 0, 0, 32'h3004);
        cyc(0, 1, 2'b00, 0, 0, 32'h3008);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the PC, issues fetch addresses to instruction memory and owns the F/D pipeline register feeding the decode stage. It consumes the decode stage's PCSrc/NPCOp redirect controls, computes branch/jump targets from the instruction held in F/D, and honours the architectural branch delay slot. It tolerates a wait-capable instruction memory by inserting bubbles and remembering redirects that resolve while a fetch is outstanding.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset.
- clk  in  1  pipeline clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  from hazard unit; freezes PC, F/D register and pending-redirect state.
- imem_addr  out  32  fetch address, equals PC.
- imem_req  out  1  fetch request; equals !stall while out of reset, 0 during reset.
- imem_rdata  in  32  fetched instruction, valid when imem_ready=1.
- imem_ready  in  1  imem_rdata valid this cycle.
- PCSrc  in  2  decode redirect select: 00 sequential, 01 j/jal/taken beq, 10 jr, 11 treated as 00.
- NPCOp  in  1  with PCSrc=01: 1 selects jump target, 0 selects branch target.
- RD1D  in  32  forwarded rs value for jr.
- InstrD  out  32  F/D instruction.
- PCD  out  32  F/D instruction address.
- PC8D  out  32  PCD+8, jal link value.

## Operation
- Registered state: PC[31:0], InstrD, PCD, pending (1 bit), pending_target[31:0].
- Target (combinational, from F/D contents):
  - PCSrc=10: {RD1D[31:2],2'b00}.
  - PCSrc=01, NPCOp=1: {PCD_plus4[31:28], InstrD[25:0], 2'b00}.
  - PCSrc=01, NPCOp=0: PCD_plus4 + {{14{InstrD[15]}}, InstrD[15:0], 2'b00}, modulo 2^32.
- redirect = (PCSrc==01 || PCSrc==10).
- Per cycle, priority top-down:
  - stall=1: all registers hold; redirect is not latched. Decode re-evaluates next cycle.
  - imem_ready=1: InstrD<=imem_rdata, PCD<=PC. PC<= redirect ? target : pending ? pending_target : PC+4. pending<=0.
  - imem_ready=0: InstrD<=0 and PCD<=0 (nop bubble); PC holds. If redirect, then pending<=1 and pending_target<=target.
- Delay slot: the instruction fetched in the cycle the branch sits in D is always kept and is never squashed. If that fetch is delayed, the redirect is parked in pending and applied after the delay-slot fetch completes.
- Redirect while pending=1: the new target overwrites pending_target. This cannot occur architecturally, because D holds a bubble.
- PC[1:0] always 00.

## Timing
- Reset (asynchronous, immediate): PC=RESET_PC, InstrD=0, PCD=0, PC8D=8, pending=0, pending_target=0, imem_req=0.
- First request occurs the cycle after reset deasserts, at RESET_PC.
- Fetch latency: 1 cycle with zero-wait memory. The instruction at PC appears on InstrD after the next rising edge.
- Redirect latency: the target is fetched 2 cycles after the branch enters D, with the delay slot in between. No cycle is lost with zero-wait memory.
- Each imem_ready=0 cycle injects exactly one bubble.
- stall and imem_ready=0 together: stall wins, no bubble is inserted and InstrD holds.
- Reset mid-wait or with pending=1: pending is cleared and fetch restarts at RESET_PC.

## Test plan
- Reset then sequential fetch, ready always 1: imem_addr goes 0x3000, 0x3004, 0x3008. InstrD/PCD follow one cycle later. PC8D = PCD+8.
- beq at 0x3000, offset 0x0003, Equal so PCSrc=01 and NPCOp=0: addresses are 0x3000, 0x3004 (delay slot), then 0x3010.
- j with instr_index 0x0000C10 at 0x3008 (PCSrc=01, NPCOp=1): next fetches are 0x300C, then 0x3040.
- jr with RD1D=0x0000_3103 (PCSrc=10): after the delay slot, PC=0x3100, low bits forced to 00.
- beq resolves at 0x3000 while imem_ready=0 for 2 cycles: two bubbles appear (InstrD=0), pending=1. When ready, 0x3004 is fetched, then 0x3010, and pending clears.
- stall=1 for 3 cycles while a branch sits in D: PC, InstrD and PCD are frozen and nothing is latched. After release, normal redirect timing applies. Asserting reset during a pending wait returns PC to 0x3000 with pending=0.
